// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM between three requesters: instruction fetch,
//   load/store unit and a custom extension. One access is granted per cycle
//   (combinational grant). The response (rvalid, err, rdata) comes one cycle
//   later on the port that won. Default priority is instr > data > cust.
//
//   Optional feature (macro RAM_ARB_AGE_EN): data and cust each get an 8-bit
//   saturating wait counter. A port that has been denied for STARVE_LIMIT
//   cycles is promoted above instr. If both are promoted, data goes first.
//   Without the macro no counters exist and priority is strictly fixed.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   instr_req_i/addr_i            fetch request, byte address
//   instr_gnt/rvalid/err_o        fetch grant, response, decode error
//   data_req/we/addr/wdata_i      LSU request, byte address
//   data_gnt/rvalid/err_o         LSU grant, response, decode error
//   cust_req/we/addr/wdata_i      custom request, 14-bit word index
//   cust_gnt/rvalid_o             custom grant, response
//   rdata_o                       shared read data, qualified by *_rvalid_o
//   mem_req/we/addr/wdata_o       RAM command
//   mem_rdata_i                   RAM read data, one cycle after mem_req_o
module ram_port_arbiter #(
   parameter logic [31:0] MEM_START    = 32'h0000_0000,
   parameter int          MEM_SIZE     = 65536,
   parameter int          STARVE_LIMIT = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   input  logic        cust_req_i,
   input  logic        cust_we_i,
   input  logic [13:0] cust_addr_i,
   input  logic [31:0] cust_wdata_i,
   output logic        cust_gnt_o,
   output logic        cust_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [13:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      OWN_IDLE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2,
      OWN_CUST  = 2'd3
   } owner_e;

   localparam logic [31:0] OFS_MASK = 32'(MEM_SIZE - 1);

   // Address decode: upper bits must match the RAM base, lower bits give
   // the byte offset whose word part addresses the RAM.
   logic        instr_in_rng;
   logic        data_in_rng;
   logic [13:0] instr_word;
   logic [13:0] data_word;

   assign instr_in_rng = (instr_addr_i & ~OFS_MASK) == MEM_START;
   assign data_in_rng  = (data_addr_i  & ~OFS_MASK) == MEM_START;
   assign instr_word   = 14'((instr_addr_i & OFS_MASK) >> 2);
   assign data_word    = 14'((data_addr_i  & OFS_MASK) >> 2);

   logic data_prom;
   logic cust_prom;

`ifdef RAM_ARB_AGE_EN
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

   logic [7:0] data_age_q, data_age_d;
   logic [7:0] cust_age_q, cust_age_d;

   // Counters track consecutive denied cycles; any gap in the request or
   // a grant restarts the count.
   always_comb begin
      data_age_d = data_age_q;
      cust_age_d = cust_age_q;
      if (!data_req_i || data_gnt_o)
         data_age_d = '0;
      else if (data_age_q != 8'hFF)
         data_age_d = data_age_q + 8'd1;
      if (!cust_req_i || cust_gnt_o)
         cust_age_d = '0;
      else if (cust_age_q != 8'hFF)
         cust_age_d = cust_age_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_age_q <= '0;
         cust_age_q <= '0;
      end else begin
         data_age_q <= data_age_d;
         cust_age_q <= cust_age_d;
      end
   end

   assign data_prom = data_req_i && (data_age_q >= STARVE_LIM);
   assign cust_prom = cust_req_i && (cust_age_q >= STARVE_LIM);
`else
   logic unused_cfg;
   assign unused_cfg = (STARVE_LIMIT != 0);
   assign data_prom  = 1'b0;
   assign cust_prom  = 1'b0;
`endif

   // Winner selection; nothing is granted while in reset.
   owner_e win;

   always_comb begin
      win = OWN_IDLE;
      if (!rst_i) begin
         if (data_prom)
            win = OWN_DATA;
         else if (cust_prom)
            win = OWN_CUST;
         else if (instr_req_i)
            win = OWN_INSTR;
         else if (data_req_i)
            win = OWN_DATA;
         else if (cust_req_i)
            win = OWN_CUST;
      end
   end

   assign instr_gnt_o = (win == OWN_INSTR);
   assign data_gnt_o  = (win == OWN_DATA);
   assign cust_gnt_o  = (win == OWN_CUST);

   // RAM command for the winner. An out-of-range winner is still granted
   // but never reaches the RAM; it is flagged for an error response.
   logic win_err;
   logic win_rd;

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      win_err     = 1'b0;
      win_rd      = 1'b0;
      unique case (win)
         OWN_INSTR: begin
            win_rd  = 1'b1;
            win_err = !instr_in_rng;
            if (instr_in_rng) begin
               mem_req_o  = 1'b1;
               mem_addr_o = instr_word;
            end
         end
         OWN_DATA: begin
            win_rd  = !data_we_i;
            win_err = !data_in_rng;
            if (data_in_rng) begin
               mem_req_o   = 1'b1;
               mem_we_o    = data_we_i;
               mem_addr_o  = data_word;
               mem_wdata_o = data_wdata_i;
            end
         end
         OWN_CUST: begin
            win_rd      = !cust_we_i;
            mem_req_o   = 1'b1;
            mem_we_o    = cust_we_i;
            mem_addr_o  = cust_addr_i;
            mem_wdata_o = cust_wdata_i;
         end
         default: ;
      endcase
   end

   // Response steering state: who won last cycle, whether it was a read,
   // and whether it was a decode error.
   owner_e owner_q, owner_d;
   logic   err_q, err_d;
   logic   rd_q, rd_d;

   always_comb begin
      owner_d = win;
      err_d   = win_err;
      rd_d    = win_rd;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q <= OWN_IDLE;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         owner_q <= owner_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
      end
   end

   // Gating with rst_i drops the response of a grant made just before reset.
   logic resp_vld;
   assign resp_vld = !rst_i && (owner_q != OWN_IDLE);

   assign instr_rvalid_o = resp_vld && (owner_q == OWN_INSTR);
   assign data_rvalid_o  = resp_vld && (owner_q == OWN_DATA);
   assign cust_rvalid_o  = resp_vld && (owner_q == OWN_CUST);
   assign instr_err_o    = instr_rvalid_o && err_q;
   assign data_err_o     = data_rvalid_o && err_q;
   assign rdata_o        = (resp_vld && rd_q && !err_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural RAM model.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt, instr_rvalid, instr_err;
   logic        data_req, data_we;
   logic [31:0] data_addr, data_wdata;
   logic        data_gnt, data_rvalid, data_err;
   logic        cust_req, cust_we;
   logic [13:0] cust_addr;
   logic [31:0] cust_wdata;
   logic        cust_gnt, cust_rvalid;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   ram_port_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr),
      .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_err_o(instr_err),
      .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata),
      .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_err_o(data_err),
      .cust_req_i(cust_req), .cust_we_i(cust_we), .cust_addr_i(cust_addr),
      .cust_wdata_i(cust_wdata),
      .cust_gnt_o(cust_gnt), .cust_rvalid_o(cust_rvalid),
      .rdata_o(rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // RAM model with a side port used only to preload contents.
   logic [31:0] ram [0:16383];
   logic        pl_we;
   logic [13:0] pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_we)
         ram[pl_addr] <= pl_data;
      else if (mem_req) begin
         if (mem_we)
            ram[mem_addr] <= mem_wdata;
         else
            mem_rdata <= ram[mem_addr];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
      next_cycle();
      pl_we   = 1'b0;
   endtask

   int   first_gnt;
   logic instr_at_gnt;

   initial begin
      rst = 1'b1;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      instr_req = 1'b1; instr_addr = 32'h10;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20; data_wdata = '0;
      cust_req = 1'b1; cust_we = 1'b0; cust_addr = 14'd9; cust_wdata = '0;

      // Reset holds everything quiet even with all requests up
      @(negedge clk);
      check_eq("rst_gnt", {instr_gnt, data_gnt, cust_gnt}, 32'd0);
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_mem_we", mem_we, 1'b0);
      check_eq("rst_rvalid", {instr_rvalid, data_rvalid, cust_rvalid}, 32'd0);
      check_eq("rst_err", {instr_err, data_err}, 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      next_cycle();
      instr_req = 1'b0; data_req = 1'b0; cust_req = 1'b0;
      preload(14'd4, 32'hDEADBEEF);
      preload(14'd8, 32'h1111_1111);
      preload(14'd9, 32'h2222_2222);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_rvalid", {instr_rvalid, data_rvalid, cust_rvalid}, 32'd0);
      next_cycle();

      // Instruction read of word 4
      instr_req = 1'b1; instr_addr = 32'h0000_0010;
      @(negedge clk);
      check_eq("i_rd_gnt", instr_gnt, 1'b1);
      check_eq("i_rd_mem_req", mem_req, 1'b1);
      check_eq("i_rd_mem_addr", mem_addr, 14'd4);
      check_eq("i_rd_mem_we", mem_we, 1'b0);
      next_cycle();
      instr_req = 1'b0;
      @(negedge clk);
      check_eq("i_rd_rvalid", instr_rvalid, 1'b1);
      check_eq("i_rd_rdata", rdata, 32'hDEADBEEF);
      check_eq("i_rd_err", instr_err, 1'b0);
      next_cycle();

      // All three at once: instr, then data, then cust
      instr_req = 1'b1; instr_addr = 32'h10;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20;
      cust_req = 1'b1; cust_we = 1'b0; cust_addr = 14'd9;
      @(negedge clk);
      check_eq("all_c1_gnt", {instr_gnt, data_gnt, cust_gnt}, 32'b100);
      next_cycle();
      instr_req = 1'b0;
      @(negedge clk);
      check_eq("all_c2_gnt", {instr_gnt, data_gnt, cust_gnt}, 32'b010);
      check_eq("all_c2_rvalid", {instr_rvalid, data_rvalid, cust_rvalid}, 32'b100);
      check_eq("all_c2_rdata", rdata, 32'hDEADBEEF);
      next_cycle();
      data_req = 1'b0;
      @(negedge clk);
      check_eq("all_c3_gnt", {instr_gnt, data_gnt, cust_gnt}, 32'b001);
      check_eq("all_c3_rvalid", {instr_rvalid, data_rvalid, cust_rvalid}, 32'b010);
      check_eq("all_c3_rdata", rdata, 32'h1111_1111);
      next_cycle();
      cust_req = 1'b0;
      @(negedge clk);
      check_eq("all_c4_gnt", {instr_gnt, data_gnt, cust_gnt}, 32'b000);
      check_eq("all_c4_rvalid", {instr_rvalid, data_rvalid, cust_rvalid}, 32'b001);
      check_eq("all_c4_rdata", rdata, 32'h2222_2222);
      next_cycle();

      // Out-of-range data write
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0001_0000; data_wdata = 32'hCAFE;
      @(negedge clk);
      check_eq("oor_gnt", data_gnt, 1'b1);
      check_eq("oor_mem_req", mem_req, 1'b0);
      next_cycle();
      data_req = 1'b0; data_we = 1'b0;
      @(negedge clk);
      check_eq("oor_rvalid", data_rvalid, 1'b1);
      check_eq("oor_err", data_err, 1'b1);
      check_eq("oor_rdata", rdata, 32'd0);
      check_eq("oor_instr_err", instr_err, 1'b0);
      next_cycle();
      @(negedge clk);
      check_eq("oor_err_clear", {data_err, data_rvalid}, 32'd0);
      next_cycle();

      // Custom write then back-to-back read of the top word
      cust_req = 1'b1; cust_we = 1'b1; cust_addr = 14'h3FFF; cust_wdata = 32'h1234;
      @(negedge clk);
      check_eq("c_wr_gnt", cust_gnt, 1'b1);
      check_eq("c_wr_mem_we", mem_we, 1'b1);
      check_eq("c_wr_mem_addr", mem_addr, 14'h3FFF);
      check_eq("c_wr_mem_wdata", mem_wdata, 32'h1234);
      next_cycle();
      cust_we = 1'b0;
      @(negedge clk);
      check_eq("c_rd_gnt", cust_gnt, 1'b1);
      check_eq("c_rd_mem_we", mem_we, 1'b0);
      check_eq("c_wr_rvalid", cust_rvalid, 1'b1);
      check_eq("c_wr_rdata", rdata, 32'd0);
      next_cycle();
      cust_req = 1'b0;
      @(negedge clk);
      check_eq("c_rd_rvalid", cust_rvalid, 1'b1);
      check_eq("c_rd_rdata", rdata, 32'h0000_1234);
      next_cycle();

      // Starvation: instr held high, data waiting
      first_gnt = -1; instr_at_gnt = 1'b1;
      instr_req = 1'b1; instr_addr = 32'h10;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_gnt && first_gnt < 0) begin
            first_gnt    = i;
            instr_at_gnt = instr_gnt;
         end
         next_cycle();
         if (first_gnt >= 0) data_req = 1'b0;
      end
`ifdef RAM_ARB_AGE_EN
      check_eq("starve_gnt_cycle", first_gnt, 32'd8);
      check_eq("starve_instr_held", instr_at_gnt, 1'b0);
`else
      check_eq("starve_never_gnt", first_gnt, 32'hFFFF_FFFF);
`endif
      instr_req = 1'b0; data_req = 1'b0;
      next_cycle();

      // Reset in the cycle after a data read grant
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20;
      @(negedge clk);
      check_eq("rr_gnt", data_gnt, 1'b1);
      next_cycle();
      data_req = 1'b0; rst = 1'b1; instr_req = 1'b1;
      @(negedge clk);
      check_eq("rr_rvalid", data_rvalid, 1'b0);
      check_eq("rr_gnt_off", {instr_gnt, data_gnt, cust_gnt}, 32'd0);
      check_eq("rr_mem", {mem_req, mem_we}, 32'd0);
      check_eq("rr_rdata", rdata, 32'd0);
      check_eq("rr_err", {instr_err, data_err}, 32'd0);
      next_cycle();
      rst = 1'b0; instr_req = 1'b0;
      @(negedge clk);
      check_eq("rr_after_rvalid", {instr_rvalid, data_rvalid, cust_rvalid}, 32'd0);
      next_cycle();

      // Normal operation resumes
      instr_req = 1'b1; instr_addr = 32'h10;
      @(negedge clk);
      check_eq("resume_gnt", instr_gnt, 1'b1);
      next_cycle();
      instr_req = 1'b0;
      @(negedge clk);
      check_eq("resume_rdata", rdata, 32'hDEADBEEF);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
